// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - sequential ALU with handshake; iterative shift-add multiply and restoring divide.
// Define SEQ_ALU_FLAGS_EN to build the Zero/DivByZero flag registers; otherwise both outputs tie to 0.
module seq_alu #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALU_Sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] ALU_Out,
  output logic             CarryOut,
  output logic             Zero,
  output logic             DivByZero,
  output logic             out_valid,
  input  logic             out_ready
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t state, state_next;

  logic                 accept;
  logic [5:0]           cnt;
  logic [WIDTH-1:0]     a_q;
  logic [WIDTH-1:0]     b_q;
  logic [2*WIDTH-1:0]   prod;
  logic [WIDTH-1:0]     rem;
  logic [WIDTH-1:0]     quo;

  logic [WIDTH:0]       sum_ext;
  logic [WIDTH:0]       diff_ext;
  logic [WIDTH-1:0]     simple_res;
  logic                 simple_carry;

  logic [WIDTH:0]       mul_add;
  logic [2*WIDTH-1:0]   prod_next;
  logic [WIDTH:0]       div_shift;
  logic [WIDTH:0]       div_trial;
  logic [WIDTH-1:0]     rem_next;
  logic [WIDTH-1:0]     quo_next;

  logic                 load;
  logic [WIDTH-1:0]     res_d;
  logic                 carry_d;
  logic                 dbz_d;
  logic [WIDTH-1:0]     alu_out_q;
  logic                 carry_q;

  assign accept = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (ALU_Sel == 4'h2) begin
            state_next = MUL;
          end else if (ALU_Sel == 4'h3 && B != '0) begin
            state_next = DIV;
          end else begin
            state_next = DONE;
          end
        end
      end
      MUL, DIV: begin
        if (cnt == 6'd0) begin
          state_next = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Single-cycle ops evaluate straight from the ports in the accept cycle.
  always_comb begin
    sum_ext      = {1'b0, A} + {1'b0, B};
    diff_ext     = {1'b0, A} - {1'b0, B};
    simple_res   = '0;
    simple_carry = 1'b0;
    case (ALU_Sel)
      4'h0: begin
        simple_res   = sum_ext[WIDTH-1:0];
        simple_carry = sum_ext[WIDTH];
      end
      4'h1: begin
        simple_res   = diff_ext[WIDTH-1:0];
        simple_carry = diff_ext[WIDTH];
      end
      4'h3: simple_res = '1;
      4'h4: simple_res = {A[WIDTH-2:0], 1'b0};
      4'h5: simple_res = {1'b0, A[WIDTH-1:1]};
      4'h6: simple_res = {A[WIDTH-2:0], A[WIDTH-1]};
      4'h7: simple_res = {A[0], A[WIDTH-1:1]};
      4'h8: simple_res = A & B;
      4'h9: simple_res = A | B;
      4'hA: simple_res = A ^ B;
      4'hB: simple_res = ~(A | B);
      4'hC: simple_res = ~(A & B);
      4'hD: simple_res = ~(A ^ B);
      4'hE: simple_res = {{(WIDTH-1){1'b0}}, (A > B)};
      4'hF: simple_res = {{(WIDTH-1){1'b0}}, (A == B)};
      default: simple_res = '0;
    endcase
  end

  // prod holds {partial sum, remaining multiplier bits}; both shift right each step.
  always_comb begin
    mul_add   = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
    prod_next = {mul_add, prod[WIDTH-1:1]};
    div_shift = {rem, quo[WIDTH-1]};
    div_trial = div_shift - {1'b0, b_q};
    rem_next  = div_trial[WIDTH] ? div_shift[WIDTH-1:0] : div_trial[WIDTH-1:0];
    quo_next  = {quo[WIDTH-2:0], ~div_trial[WIDTH]};
  end

  always_comb begin
    load    = 1'b0;
    res_d   = simple_res;
    carry_d = simple_carry;
    dbz_d   = 1'b0;
    case (state)
      IDLE: begin
        load  = accept && (ALU_Sel != 4'h2) && !(ALU_Sel == 4'h3 && B != '0);
        dbz_d = (ALU_Sel == 4'h3);
      end
      MUL: begin
        load    = (cnt == 6'd0);
        res_d   = prod_next[WIDTH-1:0];
        carry_d = |prod_next[2*WIDTH-1:WIDTH];
      end
      DIV: begin
        load    = (cnt == 6'd0);
        res_d   = quo_next;
        carry_d = 1'b0;
      end
      default: load = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_out_q <= '0;
      carry_q   <= 1'b0;
      cnt       <= '0;
      a_q       <= '0;
      b_q       <= '0;
      prod      <= '0;
      rem       <= '0;
      quo       <= '0;
    end else begin
      if (accept) begin
        a_q  <= A;
        b_q  <= B;
        cnt  <= 6'(WIDTH - 1);
        prod <= {{WIDTH{1'b0}}, B};
        rem  <= '0;
        quo  <= A;
      end else if (state == MUL) begin
        prod <= prod_next;
        cnt  <= cnt - 6'd1;
      end else if (state == DIV) begin
        rem  <= rem_next;
        quo  <= quo_next;
        cnt  <= cnt - 6'd1;
      end
      if (load) begin
        alu_out_q <= res_d;
        carry_q   <= carry_d;
      end
    end
  end

  assign ALU_Out  = alu_out_q;
  assign CarryOut = carry_q;

`ifdef SEQ_ALU_FLAGS_EN
  logic zero_q;
  logic dbz_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      zero_q <= 1'b0;
      dbz_q  <= 1'b0;
    end else if (load) begin
      zero_q <= (res_d == '0);
      dbz_q  <= dbz_d;
    end
  end

  assign Zero      = zero_q;
  assign DivByZero = dbz_q;
`else
  logic unused_dbz;
  assign unused_dbz = dbz_d;
  assign Zero       = 1'b0;
  assign DivByZero  = 1'b0;
`endif

endmodule
